// File: rtl/irq_arbiter_if.sv
// Register-bus and interrupt-handshake bundle for irq_arbiter.
// No latency of its own; the arbiter registers every output.
// No backpressure: strobes are single-cycle, CPU acks are level-sampled.
interface irq_arbiter_if;
  logic        i_WEnable;
  logic [31:0] i_WAddr;
  logic [31:0] i_WData;
  logic        i_REnable;
  logic [31:0] i_RAddr;
  logic [31:0] o_RData;
  logic        o_Err;
  logic [3:0]  i_IntSrc;
  logic        i_AckAttended;
  logic        i_AckComplete;
  logic        o_IrqReq;
  logic [1:0]  o_IrqNum;

  // Arbiter side.
  modport slave (
    input  i_WEnable, i_WAddr, i_WData,
    input  i_REnable, i_RAddr,
    output o_RData, o_Err,
    input  i_IntSrc, i_AckAttended, i_AckComplete,
    output o_IrqReq, o_IrqNum
  );

  // CPU / bus-master side.
  modport master (
    output i_WEnable, i_WAddr, i_WData,
    output i_REnable, i_RAddr,
    input  o_RData, o_Err,
    output i_IntSrc, i_AckAttended, i_AckComplete,
    input  o_IrqReq, o_IrqNum
  );
endinterface

// File: rtl/irq_arbiter.sv
// 4-source edge-triggered interrupt arbiter with CSR bank; optional IRQ_ARB_PRIO_PROG_EN adds programmable priority.
// Latency: source edge at k -> pend at k, o_IrqReq at k+1; register read/err data one cycle after strobe.
// No backpressure: a request not attended within TIMEOUT_CYC cycles is withdrawn and retried.
module irq_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic         i_Clk,
  input logic         i_Rst,
  irq_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_CTRL   = 32'd0;
  localparam logic [31:0] ADDR_PEND   = 32'd1;
  localparam logic [31:0] ADDR_PRIO   = 32'd2;
  localparam logic [31:0] ADDR_STATUS = 32'd3;
  localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        ea_q, ea_d;
  logic [3:0]  en_q, en_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic [1:0]  irq_num_q, irq_num_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef IRQ_ARB_PRIO_PROG_EN
  logic [7:0]  prio_q, prio_d;
`endif

  logic [3:0]  rise;
  logic [3:0]  elig;
  logic        any_elig;
  logic [1:0]  win;
  logic [3:0]  grant_clr;
  logic        timeout_set;
  logic        wr_mapped, rd_mapped;
  logic        wr_ok, rd_ok;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Upper write-data bits carry no register content.
  assign unused_wdata = ^bus.i_WData[31:5];

  function automatic logic addr_mapped(input logic [31:0] a);
    logic m;
    m = (a == ADDR_CTRL) || (a == ADDR_PEND) || (a == ADDR_STATUS);
`ifdef IRQ_ARB_PRIO_PROG_EN
    m = m || (a == ADDR_PRIO);
`endif
    return m;
  endfunction

  assign rise      = bus.i_IntSrc & ~prev_q;
  assign elig      = ea_q ? (pend_q & en_q) : 4'b0000;
  assign any_elig  = |elig;
  assign wr_mapped = addr_mapped(bus.i_WAddr);
  assign rd_mapped = addr_mapped(bus.i_RAddr);
  // A write shadows a simultaneous read completely.
  assign wr_ok     = bus.i_WEnable & wr_mapped;
  assign rd_ok     = ~bus.i_WEnable & bus.i_REnable & rd_mapped;

`ifdef IRQ_ARB_PRIO_PROG_EN
  // Pick the highest programmed level; strict compare keeps the lower index on ties.
  always_comb begin
    logic [1:0] best;
    logic       found;
    win   = 2'd0;
    best  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (elig[i] && (!found || prio_q[2*i +: 2] > best)) begin
        win   = 2'(i);
        best  = prio_q[2*i +: 2];
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest-numbered eligible source wins.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) win = 2'(i);
    end
  end
`endif

  // Grant state machine: next state, timeout counter, latched winner.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    irq_num_d   = irq_num_q;
    grant_clr   = 4'b0000;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          irq_num_d = win;
          cnt_d     = 16'd0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.i_AckAttended) begin
          grant_clr[irq_num_q] = 1'b1;
          state_d              = ST_SERVICE;
        end else if (!ea_q || !en_q[irq_num_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SERVICE: begin
        // No nesting: new grants wait until the handler completes.
        if (bus.i_AckComplete) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-data selection for mapped addresses.
  always_comb begin
    rd_mux = 32'd0;
    case (bus.i_RAddr)
      ADDR_CTRL:   rd_mux = {27'd0, en_q, ea_q};
      ADDR_PEND:   rd_mux = {28'd0, pend_q};
`ifdef IRQ_ARB_PRIO_PROG_EN
      ADDR_PRIO:   rd_mux = {24'd0, prio_q};
`endif
      ADDR_STATUS: rd_mux = {23'd0, sticky_q, 2'b00, state_q, 2'b00, irq_num_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  // CSR next-state: writes, pend set/clear (set wins), sticky, read/err capture.
  always_comb begin
    logic [3:0] w1c;
    ea_d     = ea_q;
    en_d     = en_q;
    sticky_d = sticky_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    w1c      = 4'b0000;
`ifdef IRQ_ARB_PRIO_PROG_EN
    prio_d   = prio_q;
`endif
    if (wr_ok && bus.i_WAddr == ADDR_CTRL) begin
      ea_d = bus.i_WData[0];
      en_d = bus.i_WData[4:1];
    end
    if (wr_ok && bus.i_WAddr == ADDR_PEND) w1c = bus.i_WData[3:0];
`ifdef IRQ_ARB_PRIO_PROG_EN
    if (wr_ok && bus.i_WAddr == ADDR_PRIO) prio_d = bus.i_WData[7:0];
`endif
    if (wr_ok && bus.i_WAddr == ADDR_STATUS) sticky_d = 1'b0;
    if (timeout_set) sticky_d = 1'b1;
    pend_d = (pend_q & ~(w1c | grant_clr)) | rise;
    if (bus.i_WEnable) begin
      err_d = ~wr_mapped;
    end else if (bus.i_REnable) begin
      err_d = ~rd_mapped;
    end
    if (rd_ok) rdata_d = rd_mux;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      ea_q      <= 1'b0;
      en_q      <= 4'b0000;
      pend_q    <= 4'b0000;
      prev_q    <= 4'b0000;
      cnt_q     <= 16'd0;
      sticky_q  <= 1'b0;
      irq_num_q <= 2'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
`ifdef IRQ_ARB_PRIO_PROG_EN
      prio_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      prev_q    <= bus.i_IntSrc;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      irq_num_q <= irq_num_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef IRQ_ARB_PRIO_PROG_EN
      prio_q    <= prio_d;
`endif
    end
  end

  assign bus.o_IrqReq = (state_q == ST_REQ);
  assign bus.o_IrqNum = irq_num_q;
  assign bus.o_RData  = rdata_q;
  assign bus.o_Err    = err_q;

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 1024, cycles REQ may stay unattended before abort (range 2..65535).
REQ-002 SHALL have port: i_Clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port: i_Rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: i_WEnable in 1 write strobe; i_WAddr in 32 write word address; i_WData in 32 write data.
REQ-005 SHALL have ports: i_REnable in 1 read strobe; i_RAddr in 32 read word address; o_RData out 32 registered read data.
REQ-006 SHALL have port: o_Err  out  1  registered access error for last strobed access.
REQ-007 SHALL have port: i_IntSrc  in  4  level interrupt sources, rising-edge sensitive, synchronous to i_Clk.
REQ-008 SHALL have ports: i_AckAttended in 1 CPU took vector; i_AckComplete in 1 CPU finished handler.
REQ-009 SHALL have ports: o_IrqReq out 1 request to CPU; o_IrqNum out 2 granted source index.

Function
REQ-010 Register map (full 32-bit address compare): 0 CTRL {en[3:0] at [4:1], ea at [0]} RW; 1 PEND [3:0] read, write-1-to-clear; 2 PRIO (see Configuration); 3 STATUS read-only {timeout sticky [8], state [5:4], o_IrqNum [1:0]}, write to 3 clears the sticky.
REQ-011 Write takes priority over read when both strobes set; the read is dropped.
REQ-012 Mapped access sets o_Err=0 next cycle; unmapped access sets o_Err=1 and changes no state; o_Err and o_RData hold between accesses.
REQ-013 Edge detect: prev[i] registered each cycle; pend[i] sets at edge k where i_IntSrc[i]=1 and prev[i]=0, regardless of en/ea.
REQ-014 Same-cycle set and clear (W1C or grant) of one pend bit: set wins.
REQ-015 Eligible = pend & en, considered only when ea=1.
REQ-016 FSM states IDLE(0), REQ(1), SERVICE(2).
REQ-017 IDLE: if any eligible, latch winner into o_IrqNum, go REQ; o_IrqReq=1 from the next edge, so pend set at edge k gives o_IrqReq=1 at edge k+1.
REQ-018 REQ: o_IrqReq=1, o_IrqNum stable; on i_AckAttended clear pend[o_IrqNum], go SERVICE.
REQ-019 REQ: 16-bit counter counts cycles; when it reaches TIMEOUT_CYC-1 without ack, set timeout sticky, go IDLE, keep pend.
REQ-020 REQ: ea cleared or winner's en cleared, go IDLE next edge, pend kept; i_AckComplete ignored.
REQ-021 SERVICE: o_IrqReq=0, no new grant (no nesting); on i_AckComplete go IDLE; i_AckAttended ignored.
REQ-022 Counter resets to 0 on every entry to REQ.

Reset
REQ-023 On i_Rst: state IDLE, ea=0, en=0, pend=0, prev=0, counter=0, sticky=0, o_IrqReq=0, o_IrqNum=0, o_RData=0, o_Err=0; PRIO=0 when present.
REQ-024 Reset mid-REQ or mid-SERVICE drops o_IrqReq the next edge; pending sources are lost.

Configuration
REQ-025 Macro IRQ_ARB_PRIO_PROG_EN: defined gives PRIO register at address 2, 2 bits per source (src i at [2i+1:2i]), RW, with the highest value winning and the lower index breaking ties.
REQ-026 Without IRQ_ARB_PRIO_PROG_EN: fixed priority, source 0 highest; address 2 is unmapped (o_Err=1).

Verification
REQ-027 Write CTRL=0x1F, pulse i_IntSrc[2] at edge k: o_IrqReq=1, o_IrqNum=2 at k+1; ack attended gives PEND=0, state 2; ack complete gives state 0.
REQ-028 en=0xF, ea=1, rise sources 1 and 3 same cycle: fixed build grants 1 then 3; PRIO=0xC0 build grants 3 first.
REQ-029 TIMEOUT_CYC=8, no ack: o_IrqReq falls after 8 cycles, STATUS[8]=1, PEND still set, re-request follows next cycle.
REQ-030 Read address 7 gives o_Err=1; then read address 0 gives o_Err=0 and o_RData=CTRL value; simultaneous W/R gives the write only.
REQ-031 Assert i_Rst during SERVICE with PEND=0x5: next edge all outputs 0, PEND=0, CTRL=0.
REQ-032 Source edge on the same cycle as W1C of that bit: PEND bit remains 1.
